// File: rtl/rdptr_gray.sv
// rtl/rdptr_gray.sv - read-side Gray/binary FIFO pointer with synchronised write pointer and status flags
// Level counter and almost_empty are built only when RDPTR_LEVEL_EN is defined.
module rdptr_gray #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              fifo_Empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
  logic [ADDR_W:0]                  wr_sync;
  logic [ADDR_W:0]                  rd_bin;
  logic [ADDR_W:0]                  rd_bin_next;
  logic [ADDR_W:0]                  rd_gray_next;
  logic                             rd_do;

  // Flop chain only; wr_ptr_gray is Gray so at most one bit is in flight.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_sync = sync_q[SYNC_STAGES-1];

  assign rd_do        = rd_en & ~fifo_Empty;
  assign rd_bin_next  = rd_bin + {{ADDR_W{1'b0}}, rd_do};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      fifo_Empty  <= 1'b1;
      underflow   <= 1'b0;
    end else begin
      rd_bin      <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
      fifo_Empty  <= (rd_gray_next == wr_sync);
      underflow   <= rd_en & fifo_Empty;
    end
  end

  assign rd_addr = rd_bin[ADDR_W-1:0];

`ifdef RDPTR_LEVEL_EN
  localparam logic [ADDR_W:0] AE_LIM = AE_THRESH[ADDR_W:0];

  logic [ADDR_W:0] wr_bin;
  logic [ADDR_W:0] level_next;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wr_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wr_bin[i] = ^(wr_sync >> i);
    end
  end

  assign level_next = wr_bin - rd_bin_next;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_level     <= level_next;
      almost_empty <= (level_next <= AE_LIM);
    end
  end
`else
  assign rd_level     = '0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_rdptr_gray.sv
// tb/tb_rdptr_gray.sv - directed and randomized checks of rdptr_gray against a count-based FIFO model
module tb_rdptr_gray;
  localparam int ADDR_W      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int AE_THRESH   = 2;
  localparam int DEPTH       = 16;
  localparam int PMOD        = 32;

  logic              rd_clk = 1'b0;
  logic              rd_rst;
  logic              rd_en;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              fifo_Empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              underflow;

  rdptr_gray #(
    .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES), .AE_THRESH(AE_THRESH)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .wr_ptr_gray(wr_ptr_gray),
    .rd_addr(rd_addr), .rd_ptr_gray(rd_ptr_gray), .fifo_Empty(fifo_Empty),
    .almost_empty(almost_empty), .rd_level(rd_level), .underflow(underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  // Model: total words read and written (mod 2*DEPTH); write count seen after a queue delay.
  int m_rd;
  int m_wr;
  int m_level;
  bit m_empty;
  bit m_under;
  int wr_seen_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic drive_wr(input int b);
    int g;
    m_wr = b % PMOD;
    g = gray(m_wr);
    wr_ptr_gray = g[ADDR_W:0];
  endtask

  task automatic model_reset();
    m_rd    = 0;
    m_level = 0;
    m_empty = 1'b1;
    m_under = 1'b0;
    wr_seen_q = {};
    for (int i = 0; i < SYNC_STAGES; i++) wr_seen_q.push_back(0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_addr"},  32'(rd_addr),     32'(m_rd % DEPTH));
    check({tag, "_gray"},  32'(rd_ptr_gray), 32'(gray(m_rd)));
    check({tag, "_empty"}, 32'(fifo_Empty),  32'(m_empty));
    check({tag, "_under"}, 32'(underflow),   32'(m_under));
`ifdef RDPTR_LEVEL_EN
    check({tag, "_level"}, 32'(rd_level),     32'(m_level));
    check({tag, "_ae"},    32'(almost_empty), 32'(m_level <= AE_THRESH));
`else
    check({tag, "_level"}, 32'(rd_level),     32'(0));
    check({tag, "_ae"},    32'(almost_empty), 32'(0));
`endif
  endtask

  // One rd_clk cycle: model advances on the edge, outputs compared at the following negedge.
  task automatic tick(input string tag);
    int vis;
    @(posedge rd_clk);
    vis = wr_seen_q.pop_front();
    wr_seen_q.push_back(m_wr);
    m_under = rd_en && m_empty;
    if (rd_en && !m_empty) m_rd = (m_rd + 1) % PMOD;
    m_level = (vis - m_rd + PMOD) % PMOD;
    m_empty = (m_level == 0);
    @(negedge rd_clk);
    check_outputs(tag);
  endtask

  // Reset asserted between edges; outputs must react before the next edge.
  task automatic async_reset(input string tag);
    #2 rd_rst = 1'b1;
    #1;
    check({tag, "_rst_gray"},  32'(rd_ptr_gray), 32'(0));
    check({tag, "_rst_addr"},  32'(rd_addr),     32'(0));
    check({tag, "_rst_empty"}, 32'(fifo_Empty),  32'(1));
    check({tag, "_rst_under"}, 32'(underflow),   32'(0));
    check({tag, "_rst_level"}, 32'(rd_level),    32'(0));
`ifdef RDPTR_LEVEL_EN
    check({tag, "_rst_ae"},    32'(almost_empty), 32'(1));
`else
    check({tag, "_rst_ae"},    32'(almost_empty), 32'(0));
`endif
    model_reset();
    drive_wr(0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    check_outputs({tag, "_rel"});
  endtask

  initial begin
    int exp_addr [6];
    rd_rst = 1'b0;
    rd_en  = 1'b0;
    drive_wr(0);
    model_reset();
    @(negedge rd_clk);
    async_reset("init");

    // Write visibility: pointer 3 becomes visible at the 3rd edge.
    drive_wr(3);
    tick("vis1");
    tick("vis2");
    check("vis_e2_empty", 32'(fifo_Empty), 32'(1));
    tick("vis3");
    check("vis_e3_empty", 32'(fifo_Empty), 32'(0));
`ifdef RDPTR_LEVEL_EN
    check("vis_e3_level", 32'(rd_level), 32'(3));
`endif

    // Drain three words, then a refused read.
    rd_en = 1'b1;
    tick("drain1");
    check("drain1_addr", 32'(rd_addr), 32'(1));
    tick("drain2");
    tick("drain3");
    check("drain3_addr",  32'(rd_addr),    32'(3));
    check("drain3_empty", 32'(fifo_Empty), 32'(1));
    tick("drain4");
    check("drain4_under", 32'(underflow), 32'(1));
    check("drain4_addr",  32'(rd_addr),   32'(3));
    rd_en = 1'b0;
    tick("drain5");
    check("drain5_under", 32'(underflow), 32'(0));

    // Bring the read pointer to 14, then wrap through 16 to 20.
    drive_wr(14);
    repeat (3) tick("pre_wrap");
    rd_en = 1'b1;
    repeat (11) tick("to14");
    rd_en = 1'b0;
    tick("at14");
    check("at14_addr", 32'(rd_addr), 32'(14));
    drive_wr(20);
    check("wr20_gray", 32'(wr_ptr_gray), 32'(5'b11110));
    repeat (3) tick("wrap_wait");
    exp_addr = '{15, 0, 1, 2, 3, 4};
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("wrap");
      check("wrap_addr", 32'(rd_addr), 32'(exp_addr[i]));
      if (i == 1) check("wrap16_gray", 32'(rd_ptr_gray), 32'(5'b11000));
    end
    rd_en = 1'b0;
    check("wrap_empty", 32'(fifo_Empty),  32'(1));
    check("wrap_gray",  32'(rd_ptr_gray), 32'(5'b11110));

    // Reset during an active read with five words stored.
    drive_wr(25);
    repeat (3) tick("lvl5");
`ifdef RDPTR_LEVEL_EN
    check("lvl5_level", 32'(rd_level), 32'(5));
`endif
    rd_en = 1'b1;
    async_reset("midop");
    rd_en = 1'b0;
    drive_wr(4);
    tick("post1");
    tick("post2");
    check("post2_empty", 32'(fifo_Empty), 32'(1));
    tick("post3");
    check("post3_empty", 32'(fifo_Empty), 32'(0));

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 800; n++) begin
      rd_en = ($urandom_range(0, 3) != 0);
      if ((((m_wr - m_rd + PMOD) % PMOD) < DEPTH) && ($urandom_range(0, 2) != 0))
        drive_wr(m_wr + 1);
      if ($urandom_range(0, 199) == 0) async_reset("rnd");
      else tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
